// File: rtl/adc_fifo_rd_sched_if.sv
// ---------------------------------------------------------------------------
// adc_fifo_rd_sched_if
//   Bundles the FIFO read port and the outgoing stream of the ADC FIFO read
//   scheduler.
//
//   FIFO side : fifo_rd_rdy, fifo_rd_empty, fifo_rd_usedw, fifo_q (to the
//               scheduler), fifo_rd_req (from the scheduler).
//   Stream    : m_data, m_valid, m_last (from the scheduler), m_ready (to it).
//
//   master : the scheduler (issues rdreq, drives the stream).
//   slave  : the environment (FIFO plus stream consumer).
// ---------------------------------------------------------------------------
interface adc_fifo_rd_sched_if #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 10
);
    logic              fifo_rd_rdy;
    logic              fifo_rd_empty;
    logic [CNT_W-1:0]  fifo_rd_usedw;
    logic [DATA_W-1:0] fifo_q;
    logic              fifo_rd_req;

    logic [DATA_W-1:0] m_data;
    logic              m_valid;
    logic              m_ready;
    logic              m_last;

    modport master (
        input  fifo_rd_rdy,
        input  fifo_rd_empty,
        input  fifo_rd_usedw,
        input  fifo_q,
        output fifo_rd_req,
        output m_data,
        output m_valid,
        input  m_ready,
        output m_last
    );

    modport slave (
        output fifo_rd_rdy,
        output fifo_rd_empty,
        output fifo_rd_usedw,
        output fifo_q,
        input  fifo_rd_req,
        input  m_data,
        input  m_valid,
        output m_ready,
        input  m_last
    );
endinterface

// File: rtl/adc_fifo_rd_sched.sv
// ---------------------------------------------------------------------------
// adc_fifo_rd_sched
//   Reads fixed-length bursts out of the ADC capture FIFO (non-showahead,
//   q valid one cycle after rdreq) and presents them as a valid/ready stream
//   with a last marker on the final word of each burst.
//
//   State table
//     IDLE  | no burst in progress, waiting for enable
//     ARM   | waiting for fifo_rd_rdy and at least BURST_LEN words in the FIFO
//     READ  | issuing rdreqs, at most BURST_LEN per burst
//     DRAIN | all rdreqs issued, waiting for the last word to handshake
//
//   Ports
//     adc_fifo_clk_rd  read-side clock, rising edge
//     rst_n            asynchronous active-low reset
//     enable           level, permits new bursts (a running burst always finishes)
//     clr_ovf          pulse, clears overflow_sticky
//     fifo_wr_full     FIFO wrfull from the write clock domain (synchronized here)
//     rd_if            FIFO read port + output stream (master modport)
//     busy             registered, high in any state except IDLE
//     overflow_sticky  set by a synchronized wrfull, cleared by clr_ovf
//     burst_cnt        completed bursts, wrapping 16-bit
// ---------------------------------------------------------------------------
module adc_fifo_rd_sched #(
    parameter int DATA_W    = 32,
    parameter int CNT_W     = 10,
    parameter int BURST_LEN = 256
) (
    input  logic                       adc_fifo_clk_rd,
    input  logic                       rst_n,
    input  logic                       enable,
    input  logic                       clr_ovf,
    input  logic                       fifo_wr_full,
    adc_fifo_rd_sched_if.master        rd_if,
    output logic                       busy,
    output logic                       overflow_sticky,
    output logic [15:0]                burst_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        READ  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] BURST_LEN_C = CNT_W'(BURST_LEN);
    localparam logic [CNT_W-1:0] LAST_REQ_C  = CNT_W'(BURST_LEN - 1);

    state_t            state;
    logic [CNT_W-1:0]  req_cnt;

    // rd_pend marks a word arriving on fifo_q this cycle (rdreq last cycle);
    // pend_last tags it as the final word of the burst.
    logic              rd_pend;
    logic              pend_last;

    // Second buffer entry; the head entry is the m_data/m_valid/m_last
    // registers themselves.
    logic [DATA_W-1:0] sk_data;
    logic              sk_last;
    logic              sk_valid;

    logic              hs;
    logic              last_hs;
    logic              rd_req;
    logic [1:0]        occ_after;

    logic              ovf_s1;
    logic              ovf_s2;

    assign hs      = rd_if.m_valid & rd_if.m_ready;
    assign last_hs = hs & rd_if.m_last;

    // Buffered words left after this cycle's handshake plus the word landing
    // from the FIFO now. Never exceeds 2, and hs implies m_valid, so 2 bits
    // cannot wrap.
    always_comb begin
        occ_after = {1'b0, rd_if.m_valid} + {1'b0, sk_valid}
                  + {1'b0, rd_pend} - {1'b0, hs};
    end

    // rdreq is combinational so that an empty FIFO or a stalled consumer
    // stops requests in the same cycle, while back-to-back reads still run at
    // one word per clock.
    assign rd_req = (state == READ)
                  && !rd_if.fifo_rd_empty
                  && (req_cnt < BURST_LEN_C)
                  && (occ_after < 2'd2);

    assign rd_if.fifo_rd_req = rd_req;

    always_ff @(posedge adc_fifo_clk_rd or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            busy    <= 1'b0;
            req_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (enable) begin
                        state <= ARM;
                        busy  <= 1'b1;
                    end
                end
                ARM: begin
                    if (!enable) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (rd_if.fifo_rd_rdy && (rd_if.fifo_rd_usedw >= BURST_LEN_C)) begin
                        state   <= READ;
                        req_cnt <= '0;
                    end
                end
                READ: begin
                    if (rd_req) begin
                        req_cnt <= req_cnt + 1'b1;
                        if (req_cnt == LAST_REQ_C) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (last_hs) begin
                        state <= enable ? ARM : IDLE;
                        busy  <= enable;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge adc_fifo_clk_rd or negedge rst_n) begin
        if (!rst_n) begin
            burst_cnt <= '0;
        end else if (last_hs) begin
            burst_cnt <= burst_cnt + 16'd1;
        end
    end

    always_ff @(posedge adc_fifo_clk_rd or negedge rst_n) begin
        if (!rst_n) begin
            rd_pend       <= 1'b0;
            pend_last     <= 1'b0;
            rd_if.m_data  <= '0;
            rd_if.m_valid <= 1'b0;
            rd_if.m_last  <= 1'b0;
            sk_data       <= '0;
            sk_last       <= 1'b0;
            sk_valid      <= 1'b0;
        end else begin
            rd_pend   <= rd_req;
            pend_last <= rd_req && (req_cnt == LAST_REQ_C);

            if (hs) begin
                if (sk_valid) begin
                    rd_if.m_data <= sk_data;
                    rd_if.m_last <= sk_last;
                    if (rd_pend) begin
                        sk_data <= rd_if.fifo_q;
                        sk_last <= pend_last;
                    end else begin
                        sk_valid <= 1'b0;
                        sk_last  <= 1'b0;
                    end
                end else if (rd_pend) begin
                    rd_if.m_data <= rd_if.fifo_q;
                    rd_if.m_last <= pend_last;
                end else begin
                    rd_if.m_valid <= 1'b0;
                    rd_if.m_last  <= 1'b0;
                end
            end else if (rd_pend) begin
                // rdreq gating guarantees the second entry is free here.
                if (!rd_if.m_valid) begin
                    rd_if.m_data  <= rd_if.fifo_q;
                    rd_if.m_last  <= pend_last;
                    rd_if.m_valid <= 1'b1;
                end else begin
                    sk_data  <= rd_if.fifo_q;
                    sk_last  <= pend_last;
                    sk_valid <= 1'b1;
                end
            end
        end
    end

    // wrfull comes from the write clock domain; two flops before use.
    always_ff @(posedge adc_fifo_clk_rd or negedge rst_n) begin
        if (!rst_n) begin
            ovf_s1          <= 1'b0;
            ovf_s2          <= 1'b0;
            overflow_sticky <= 1'b0;
        end else begin
            ovf_s1 <= fifo_wr_full;
            ovf_s2 <= ovf_s1;
            if (ovf_s2) begin
                overflow_sticky <= 1'b1;
            end else if (clr_ovf) begin
                overflow_sticky <= 1'b0;
            end
        end
    end

endmodule
